// File: rtl/number_resizer_pkg.sv
// number_resizer_pkg: shared mode encoding for the lane width adapter.
package number_resizer_pkg;
  typedef enum logic [1:0] {ZEXT = 2'd0, SEXT = 2'd1, REPL = 2'd2, SAT = 2'd3} resize_mode_t;
endpackage

// File: rtl/number_resizer_lane.sv
// resize_lane: combinational IN_W -> OUT_W conversion of one lane.
module resize_lane
  import number_resizer_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  x_i,
  input  resize_mode_t     mode_i,
  output logic [OUT_W-1:0] y_o,
  output logic             sat_o
);
  logic [OUT_W-1:0] zx, sx, rep, lim, sat_y;
  logic             clamped;
  for (genvar b = 0; b < OUT_W; b++) begin : g_bit
    assign rep[b] = x_i[b % IN_W];
    // clamp limit: sign bit on top, its inverse below (min for negative, max for positive)
    assign lim[b] = (b == OUT_W - 1) ? x_i[IN_W-1] : ~x_i[IN_W-1];
    if (b < IN_W) begin : g_in
      assign zx[b] = x_i[b];
      assign sx[b] = x_i[b];
    end else begin : g_ext
      assign zx[b] = 1'b0;
      assign sx[b] = x_i[IN_W-1];
    end
  end
  if (OUT_W < IN_W) begin : g_narrow
    assign clamped = x_i[IN_W-1:OUT_W-1] != {(IN_W - OUT_W + 1){x_i[IN_W-1]}};
    assign sat_y   = clamped ? lim : sx;
  end else begin : g_wide
    assign clamped = 1'b0;
    assign sat_y   = sx;
  end
  assign y_o   = (mode_i == ZEXT) ? zx : (mode_i == SEXT) ? sx : (mode_i == REPL) ? rep : sat_y;
  assign sat_o = (mode_i == SAT) && clamped;
endmodule

// File: rtl/number_resizer.sv
// number_resizer: registered multi-lane width adapter with 2-entry skid buffer
// and a saturating count of beats that clamped.
module number_resizer
  import number_resizer_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IN_W   = 4,
  parameter int OUT_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_mode,
  input  logic [NUM_CH*IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*OUT_W-1:0] out_data,
  output logic [NUM_CH-1:0]       out_sat,
  output logic [CNT_W-1:0]        sat_cnt,
  input  logic                    sat_clr
);
  logic [NUM_CH*OUT_W-1:0] conv_data, main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [NUM_CH-1:0]       conv_sat, main_sat_q, main_sat_d, skid_sat_q, skid_sat_d;
  logic                    main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic                    in_ready_q, in_fire, main_take, skid_load;
  logic [CNT_W-1:0]        sat_cnt_q, sat_cnt_d;
  resize_mode_t            mode;
  assign mode = resize_mode_t'(in_mode);
  for (genvar l = 0; l < NUM_CH; l++) begin : g_lane
    resize_lane #(.IN_W(IN_W), .OUT_W(OUT_W)) u_lane (
      .x_i   (in_data[l*IN_W +: IN_W]),
      .mode_i(mode),
      .y_o   (conv_data[l*OUT_W +: OUT_W]),
      .sat_o (conv_sat[l])
    );
  end
  assign in_fire = in_valid && in_ready_q;
  // skid only fills when main is stalled; in_ready_q guarantees no input while skid is full
  always_comb begin
    main_take    = !main_valid_q || out_ready;
    skid_load    = !main_take && in_fire;
    main_valid_d = main_take ? (skid_valid_q || in_fire) : main_valid_q;
    main_data_d  = (main_take && skid_valid_q) ? skid_data_q : (main_take && in_fire) ? conv_data : main_data_q;
    main_sat_d   = (main_take && skid_valid_q) ? skid_sat_q : (main_take && in_fire) ? conv_sat : main_sat_q;
    skid_valid_d = main_take ? 1'b0 : (skid_valid_q || in_fire);
    skid_data_d  = skid_load ? conv_data : skid_data_q;
    skid_sat_d   = skid_load ? conv_sat : skid_sat_q;
    sat_cnt_d    = sat_clr ? '0 : (in_fire && |conv_sat && !(&sat_cnt_q)) ? sat_cnt_q + 1'b1 : sat_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_sat_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_sat_q   <= '0;
      in_ready_q   <= 1'b0;
      sat_cnt_q    <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_sat_q   <= main_sat_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sat_q   <= skid_sat_d;
      in_ready_q   <= !skid_valid_d;
      sat_cnt_q    <= sat_cnt_d;
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_sat   = main_sat_q;
  assign sat_cnt   = sat_cnt_q;
endmodule

// File: tb/tb_number_resizer.sv
// tb_number_resizer: directed checks of three number_resizer configurations.
module tb_number_resizer;
  import number_resizer_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  // A: defaults (2 lanes, 4 -> 8)
  logic        a_in_valid = 1'b0, a_out_ready = 1'b1, a_sat_clr = 1'b0;
  logic [1:0]  a_in_mode = 2'd0;
  logic [7:0]  a_in_data = '0;
  logic        a_in_ready, a_out_valid;
  logic [15:0] a_out_data, a_sat_cnt;
  logic [1:0]  a_out_sat;
  // B: 2 lanes, 5 -> 3, 2-bit counter
  logic        b_in_valid = 1'b0, b_out_ready = 1'b1, b_sat_clr = 1'b0;
  logic [1:0]  b_in_mode = 2'd0;
  logic [9:0]  b_in_data = '0;
  logic        b_in_ready, b_out_valid;
  logic [5:0]  b_out_data;
  logic [1:0]  b_out_sat, b_sat_cnt;
  // C: 1 lane, 3 -> 8
  logic        c_in_valid = 1'b0, c_out_ready = 1'b1, c_sat_clr = 1'b0;
  logic [1:0]  c_in_mode = 2'd0;
  logic [2:0]  c_in_data = '0;
  logic        c_in_ready, c_out_valid;
  logic [7:0]  c_out_data;
  logic [0:0]  c_out_sat;
  logic [15:0] c_sat_cnt;

  number_resizer u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_sat(a_out_sat), .sat_cnt(a_sat_cnt), .sat_clr(a_sat_clr)
  );
  number_resizer #(.NUM_CH(2), .IN_W(5), .OUT_W(3), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_sat(b_out_sat), .sat_cnt(b_sat_cnt), .sat_clr(b_sat_clr)
  );
  number_resizer #(.NUM_CH(1), .IN_W(3), .OUT_W(8), .CNT_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_mode(c_in_mode),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_sat(c_out_sat), .sat_cnt(c_sat_cnt), .sat_clr(c_sat_clr)
  );

  task automatic a_send(input logic [1:0] m, input logic [7:0] d);
    @(negedge clk); a_in_valid = 1'b1; a_in_mode = m; a_in_data = d;
    @(negedge clk); a_in_valid = 1'b0;
  endtask
  task automatic b_send(input logic [1:0] m, input logic [9:0] d);
    @(negedge clk); b_in_valid = 1'b1; b_in_mode = m; b_in_data = d;
    @(negedge clk); b_in_valid = 1'b0;
  endtask
  task automatic c_send(input logic [1:0] m, input logic [2:0] d);
    @(negedge clk); c_in_valid = 1'b1; c_in_mode = m; c_in_data = d;
    @(negedge clk); c_in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
    checks++; if (a_out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h want 0000", a_out_data); end
    checks++; if (a_sat_cnt !== 16'h0) begin errors++; $display("FAIL reset_sat_cnt got %h want 0000", a_sat_cnt); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", a_in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid got %b want 0", a_out_valid); end
  endtask

  task automatic test_sext;
    a_send(SEXT, 8'b1000_0111);
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL sext_valid got %b want 1", a_out_valid); end
    checks++; if (a_out_data !== 16'hF807) begin errors++; $display("FAIL sext_data got %h want f807", a_out_data); end
    checks++; if (a_out_sat !== 2'b00) begin errors++; $display("FAIL sext_sat got %b want 00", a_out_sat); end
  endtask

  task automatic test_modes;
    logic [1:0]  m_tab [3] = '{ZEXT, REPL, SAT};
    logic [15:0] e_tab [3] = '{16'h0A05, 16'hAA55, 16'hFA05};
    for (int i = 0; i < 3; i++) begin
      a_send(m_tab[i], 8'hA5);
      checks++; if (a_out_data !== e_tab[i]) begin errors++; $display("FAIL mode%0d_data got %h want %h", i, a_out_data, e_tab[i]); end
      checks++; if (a_out_sat !== 2'b00) begin errors++; $display("FAIL mode%0d_sat got %b want 00", i, a_out_sat); end
    end
    checks++; if (a_sat_cnt !== 16'h0) begin errors++; $display("FAIL modes_sat_cnt got %h want 0000", a_sat_cnt); end
  endtask

  task automatic test_repl_narrow_in;
    logic [1:0] m_tab [5] = '{REPL, REPL, SEXT, SAT, ZEXT};
    logic [2:0] x_tab [5] = '{3'b101, 3'b110, 3'b101, 3'b101, 3'b101};
    logic [7:0] e_tab [5] = '{8'h6D, 8'hB6, 8'hFD, 8'hFD, 8'h05};
    for (int i = 0; i < 5; i++) begin
      c_send(m_tab[i], x_tab[i]);
      checks++; if (c_out_data !== e_tab[i]) begin errors++; $display("FAIL c%0d_data got %h want %h", i, c_out_data, e_tab[i]); end
      checks++; if (c_out_sat !== 1'b0) begin errors++; $display("FAIL c%0d_sat got %b want 0", i, c_out_sat); end
    end
  endtask

  task automatic test_sat;
    b_send(SAT, {5'b01001, 5'b10111});
    checks++; if (b_out_data !== 6'b011_100) begin errors++; $display("FAIL sat_clamp_data got %b want 011100", b_out_data); end
    checks++; if (b_out_sat !== 2'b11) begin errors++; $display("FAIL sat_clamp_flags got %b want 11", b_out_sat); end
    checks++; if (b_sat_cnt !== 2'd1) begin errors++; $display("FAIL sat_clamp_cnt got %0d want 1", b_sat_cnt); end
    b_send(SAT, {5'b00010, 5'b11100});
    checks++; if (b_out_data !== 6'b010_100) begin errors++; $display("FAIL sat_fit_data got %b want 010100", b_out_data); end
    checks++; if (b_out_sat !== 2'b00) begin errors++; $display("FAIL sat_fit_flags got %b want 00", b_out_sat); end
    checks++; if (b_sat_cnt !== 2'd1) begin errors++; $display("FAIL sat_fit_cnt got %0d want 1", b_sat_cnt); end
    b_send(ZEXT, {5'b01001, 5'b10111});
    checks++; if (b_out_data !== 6'b001_111) begin errors++; $display("FAIL trunc_data got %b want 001111", b_out_data); end
    checks++; if (b_out_sat !== 2'b00) begin errors++; $display("FAIL trunc_flags got %b want 00", b_out_sat); end
    checks++; if (b_sat_cnt !== 2'd1) begin errors++; $display("FAIL trunc_cnt got %0d want 1", b_sat_cnt); end
  endtask

  task automatic test_sat_cnt;
    logic [1:0] exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
    @(negedge clk); b_sat_clr = 1'b1;
    @(negedge clk); b_sat_clr = 1'b0;
    checks++; if (b_sat_cnt !== 2'd0) begin errors++; $display("FAIL cnt_clear got %0d want 0", b_sat_cnt); end
    for (int i = 0; i < 5; i++) begin
      b_in_valid = 1'b1; b_in_mode = SAT; b_in_data = {5'b01001, 5'b10111}; b_sat_clr = (i == 4);
      @(negedge clk);
      checks++; if (b_sat_cnt !== exp[i]) begin errors++; $display("FAIL cnt_beat%0d got %0d want %0d", i, b_sat_cnt, exp[i]); end
    end
    b_in_valid = 1'b0; b_sat_clr = 1'b0;
  endtask

  task automatic test_backpressure;
    int tx = 0, rx = 0, first_low = -1, low_cnt = 0, done_c = -1;
    logic acc = 1'b0;
    logic [15:0] exp;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      a_out_ready = !(c >= 3 && c < 6);
      if (a_out_valid && a_out_ready) begin
        exp = {4'h0, 4'(rx + 8), 4'h0, 4'(rx)};
        checks++; if (a_out_data !== exp) begin errors++; $display("FAIL bp_beat%0d got %h want %h", rx, a_out_data, exp); end
        rx++;
        if (rx == 8) done_c = c;
      end
      if (acc) tx++;
      if (!a_in_ready) begin low_cnt++; if (first_low < 0) first_low = c; end
      a_in_valid = (tx < 8); a_in_mode = ZEXT; a_in_data = {4'(tx + 8), 4'(tx)};
      acc = a_in_valid && a_in_ready;
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    checks++; if (tx != 8) begin errors++; $display("FAIL bp_sent got %0d want 8", tx); end
    checks++; if (done_c != 11) begin errors++; $display("FAIL bp_last_cycle got %0d want 11", done_c); end
    checks++; if (first_low != 4) begin errors++; $display("FAIL bp_ready_drop got %0d want 4", first_low); end
    checks++; if (low_cnt != 3) begin errors++; $display("FAIL bp_ready_low got %0d want 3", low_cnt); end
  endtask

  task automatic test_reset_mid;
    b_send(SAT, {5'b01001, 5'b10111});
    checks++; if (b_sat_cnt !== 2'd1) begin errors++; $display("FAIL mid_cnt_pre got %0d want 1", b_sat_cnt); end
    @(negedge clk); a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_mode = ZEXT; a_in_data = 8'h11;
    @(negedge clk); a_in_data = 8'h22;
    @(negedge clk); a_in_valid = 1'b0;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL mid_full_ready got %b want 0", a_in_ready); end
    checks++; if (a_out_data !== 16'h0101) begin errors++; $display("FAIL mid_full_data got %h want 0101", a_out_data); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", a_out_valid); end
    checks++; if (a_out_data !== 16'h0) begin errors++; $display("FAIL mid_rst_data got %h want 0000", a_out_data); end
    checks++; if (b_sat_cnt !== 2'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d want 0", b_sat_cnt); end
    @(negedge clk); rst_n = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale got %b want 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", a_in_ready); end
    a_send(ZEXT, 8'h33);
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL mid_new_valid got %b want 1", a_out_valid); end
    checks++; if (a_out_data !== 16'h0303) begin errors++; $display("FAIL mid_new_data got %h want 0303", a_out_data); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL mid_after got %b want 0", a_out_valid); end
  endtask

  initial begin
    test_reset;
    test_sext;
    test_modes;
    test_repl_narrow_in;
    test_sat;
    test_sat_cnt;
    test_backpressure;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
